// File: rtl/pattern_sequence_serializer_pkg.sv
// rtl/pattern_sequence_serializer_pkg.sv - shared types and constants for the pattern sequence serializer
package pattern_sequence_serializer_pkg;

    localparam int SEQ_LEN_DEF = 28;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_sequence_serializer_shift_reg.sv
// rtl/pattern_sequence_serializer_shift_reg.sv - seq_shift_reg: loadable bidirectional rotating shift register
module seq_shift_reg
    import pattern_sequence_serializer_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic               lsb_first,
    input  logic [SEQ_LEN-1:0] din,
    output logic               sout_next
);

    logic [SEQ_LEN-1:0] sreg;
    logic               dir;

    // Rotating rather than shifting keeps the captured sequence intact for repeated passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            dir  <= ORDER_MSB_FIRST;
        end else if (load) begin
            sreg <= din;
            dir  <= lsb_first;
        end else if (shift) begin
            if (dir == ORDER_LSB_FIRST)
                sreg <= {sreg[0], sreg[SEQ_LEN-1:1]};
            else
                sreg <= {sreg[SEQ_LEN-2:0], sreg[SEQ_LEN-1]};
        end
    end

    // Bit that reaches the output end after the next shift.
    assign sout_next = (dir == ORDER_LSB_FIRST) ? sreg[1] : sreg[SEQ_LEN-2];

endmodule

// File: rtl/pattern_sequence_serializer.sv
// rtl/pattern_sequence_serializer.sv - parallel-to-serial stimulus source for the pattern recognizer; optional SERIALIZER_REPEAT_EN
module pattern_sequence_serializer
    import pattern_sequence_serializer_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int IDX_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
`ifdef SERIALIZER_REPEAT_EN
    input  logic               repeat_en,
`endif
    input  logic [SEQ_LEN-1:0] seq_in,
    input  logic               type_in,
    input  logic               lsb_first,
    output logic               X,
    output logic               TYPE,
    output logic               x_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             sr_load;
    logic             sr_shift;
    logic             sout_next;
    logic             rpt;

`ifdef SERIALIZER_REPEAT_EN
    assign rpt = repeat_en;
`else
    assign rpt = 1'b0;
`endif

    assign sr_load  = (state == ST_IDLE) && load;
    assign sr_shift = (state == ST_SHIFT);

    seq_shift_reg #(.SEQ_LEN(SEQ_LEN)) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .shift     (sr_shift),
        .lsb_first (lsb_first),
        .din       (seq_in),
        .sout_next (sout_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            X       <= 1'b0;
            TYPE    <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state   <= ST_SHIFT;
                        idx     <= '0;
                        TYPE    <= type_in;
                        busy    <= 1'b1;
                        x_valid <= 1'b1;
                        // First bit is taken straight from seq_in so it appears one cycle after load.
                        X       <= (lsb_first == ORDER_LSB_FIRST) ? seq_in[0] : seq_in[SEQ_LEN-1];
                    end
                end
                ST_SHIFT: begin
                    if (idx == LAST_IDX) begin
                        done <= 1'b1;
                        if (rpt) begin
                            idx <= '0;
                            X   <= sout_next;
                        end else begin
                            state   <= ST_DONE;
                            X       <= 1'b0;
                            x_valid <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                        X   <= sout_next;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sequence_serializer.sv
// tb/tb_pattern_sequence_serializer.sv - self-checking bench for pattern_sequence_serializer
module tb_pattern_sequence_serializer;

    localparam int N = 28;

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] seq_in;
    logic         type_in;
    logic         lsb_first;
    logic         X;
    logic         TYPE;
    logic         x_valid;
    logic         busy;
    logic         done;
`ifdef SERIALIZER_REPEAT_EN
    logic         repeat_en;
`endif

    int errors = 0;
    int checks = 0;

    pattern_sequence_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
`ifdef SERIALIZER_REPEAT_EN
        .repeat_en (repeat_en),
`endif
        .seq_in    (seq_in),
        .type_in   (type_in),
        .lsb_first (lsb_first),
        .X         (X),
        .TYPE      (TYPE),
        .x_valid   (x_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: transmission order is just seq read forwards or backwards.
    function automatic logic model_bit(input logic [N-1:0] seq, input logic lsb, input int i);
        return lsb ? seq[i] : seq[N-1-i];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 1) reset = 1'b0;
            checks++;
            if ({X, TYPE, x_valid, busy, done} !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got X/TYPE/valid/busy/done=%b want 00000", c,
                         {X, TYPE, x_valid, busy, done});
            end
        end
    endtask

    task automatic test_transfer(input logic [N-1:0] seq, input logic typ, input logic lsb,
                                 input bit disturb);
        load      = 1'b1;
        seq_in    = seq;
        type_in   = typ;
        lsb_first = lsb;
        tick();
        load = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({x_valid, busy, done, TYPE} !== {3'b110, typ}) begin
                errors++;
                $display("FAIL xfer_ctrl bit %0d: got valid/busy/done/TYPE=%b want %b", i,
                         {x_valid, busy, done, TYPE}, {3'b110, typ});
            end
            checks++;
            if (X !== model_bit(seq, lsb, i)) begin
                errors++;
                $display("FAIL xfer_bit %0d (lsb_first=%0b): got X=%b want %b", i, lsb, X,
                         model_bit(seq, lsb, i));
            end
            if (disturb && i == 10) begin
                load      = 1'b1;
                seq_in    = ~seq;
                type_in   = ~typ;
                lsb_first = ~lsb;
            end
            if (disturb && i == 11) load = 1'b0;
            tick();
        end
        checks++;
        if ({done, x_valid, X, busy, TYPE} !== {4'b1000, typ}) begin
            errors++;
            $display("FAIL xfer_done: got done/valid/X/busy/TYPE=%b want %b",
                     {done, x_valid, X, busy, TYPE}, {4'b1000, typ});
        end
        tick();
        checks++;
        if ({done, x_valid, busy, TYPE} !== {3'b000, typ}) begin
            errors++;
            $display("FAIL xfer_idle: got done/valid/busy/TYPE=%b want %b",
                     {done, x_valid, busy, TYPE}, {3'b000, typ});
        end
    endtask

    task automatic test_reset_abort;
        logic [N-1:0] seq;
        logic         lsb;
        seq = N'($urandom);
        lsb = 1'($urandom);
        load      = 1'b1;
        seq_in    = seq;
        type_in   = 1'b1;
        lsb_first = lsb;
        tick();
        load = 1'b0;
        for (int i = 0; i <= 15; i++) begin
            checks++;
            if ({x_valid, X} !== {1'b1, model_bit(seq, lsb, i)}) begin
                errors++;
                $display("FAIL abort_pre bit %0d: got valid/X=%b want %b", i, {x_valid, X},
                         {1'b1, model_bit(seq, lsb, i)});
            end
            if (i == 15) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({X, TYPE, x_valid, busy, done} !== 5'b0) begin
                errors++;
                $display("FAIL abort_post cycle %0d: got X/TYPE/valid/busy/done=%b want 00000", c,
                         {X, TYPE, x_valid, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] seq;
        logic         lsb;
        logic [2:0]   want;
        bit           idle_seen;
        seq = N'($urandom);
        lsb = 1'($urandom);
        seq_in    = seq;
        type_in   = 1'b1;
        lsb_first = lsb;
        load      = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            int p;
            tick();
            p = (cyc - 1) % (N + 2);
            want = (p < N) ? {1'b1, model_bit(seq, lsb, p), 1'b0} : {2'b00, (p == N)};
            checks++;
            if ({x_valid, X, done} !== want) begin
                errors++;
                $display("FAIL b2b cycle %0d: got valid/X/done=%b want %b", cyc,
                         {x_valid, X, done}, want);
            end
        end
        load = 1'b0;
        idle_seen = 1'b0;
        for (int k = 0; k < 40 && !idle_seen; k++) begin
            tick();
            if (!busy && !x_valid && !done) idle_seen = 1'b1;
        end
        checks++;
        if (!idle_seen) begin
            errors++;
            $display("FAIL b2b_drain: got busy=%b valid=%b want idle within 40 cycles", busy, x_valid);
        end
    endtask

`ifdef SERIALIZER_REPEAT_EN
    task automatic test_repeat;
        logic [N-1:0] seq;
        logic         lsb;
        bit           finished;
        seq = N'($urandom);
        lsb = 1'($urandom);
        repeat_en = 1'b1;
        seq_in    = seq;
        type_in   = 1'b0;
        lsb_first = lsb;
        load      = 1'b1;
        tick();
        load = 1'b0;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            int p;
            p = (cyc - 1) % N;
            checks++;
            if ({x_valid, X, done} !== {1'b1, model_bit(seq, lsb, p), (cyc > 1 && p == 0)}) begin
                errors++;
                $display("FAIL repeat cycle %0d: got valid/X/done=%b want %b", cyc,
                         {x_valid, X, done}, {1'b1, model_bit(seq, lsb, p), (cyc > 1 && p == 0)});
            end
            if (cyc < 90) tick();
        end
        repeat_en = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 40 && !finished; k++) begin
            tick();
            if (done && !x_valid) finished = 1'b1;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL repeat_stop: got valid=%b done=%b want final done within 40 cycles",
                     x_valid, done);
        end
        tick();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        load      = 1'b0;
        seq_in    = '0;
        type_in   = 1'b0;
        lsb_first = 1'b0;
`ifdef SERIALIZER_REPEAT_EN
        repeat_en = 1'b0;
`endif
        test_reset();
        test_transfer(28'b1010101001010101011001000101, 1'b1, 1'b1, 1'b0);
        test_transfer(28'b1010101001010101011001000101, 1'b0, 1'b0, 1'b0);
        test_transfer(N'($urandom), 1'b1, 1'b1, 1'b1);
        test_transfer(N'($urandom), 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++)
            test_transfer(N'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        test_reset_abort();
        test_transfer(N'($urandom), 1'b1, 1'($urandom), 1'b0);
        test_back_to_back();
`ifdef SERIALIZER_REPEAT_EN
        test_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
